// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter letting NM AXI read masters share one AR/R port.
// Optional sticky error flag enabled by defining AXI_RD_ARB_ERR_EN.
module axi_rd_arbiter #(
    parameter int NM        = 2,
    parameter int TIDW      = 1,
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int MAX_OUTST = 8,
    localparam int IW       = $clog2(NM),
    localparam int CW       = $clog2(MAX_OUTST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NM-1:0][TIDW-1:0]       ar_id_m,
    input  logic [NM-1:0][AW-1:0]         ar_addr_m,
    input  logic [NM-1:0][7:0]            ar_len_m,
    input  logic [NM-1:0][2:0]            ar_size_m,
    input  logic [NM-1:0][1:0]            ar_burst_m,
    input  logic [NM-1:0]                 ar_valid_m,
    output logic [NM-1:0]                 ar_ready_m,
    output logic [TIDW-1:0]               r_id_m,
    output logic [DW-1:0]                 r_data_m,
    output logic [1:0]                    r_resp_m,
    output logic                          r_last_m,
    output logic [NM-1:0]                 r_valid_m,
    input  logic [NM-1:0]                 r_ready_m,
    output logic [TIDW+IW-1:0]            ar_id_s,
    output logic [AW-1:0]                 ar_addr_s,
    output logic [7:0]                    ar_len_s,
    output logic [2:0]                    ar_size_s,
    output logic [1:0]                    ar_burst_s,
    output logic                          ar_valid_s,
    input  logic                          ar_ready_s,
    input  logic [TIDW+IW-1:0]            r_id_s,
    input  logic [DW-1:0]                 r_data_s,
    input  logic [1:0]                    r_resp_s,
    input  logic                          r_last_s,
    input  logic                          r_valid_s,
    output logic                          r_ready_s,
    output logic                          err
);

    logic                    ar_valid_q, ar_valid_d;
    logic [TIDW+IW-1:0]      ar_id_q, ar_id_d;
    logic [AW-1:0]           ar_addr_q, ar_addr_d;
    logic [7:0]              ar_len_q, ar_len_d;
    logic [2:0]              ar_size_q, ar_size_d;
    logic [1:0]              ar_burst_q, ar_burst_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [NM-1:0][CW-1:0]   cnt_q, cnt_d;

    logic [NM-1:0]           elig;
    logic [IW-1:0]           win, hi_win, lo_win, k;
    logic                    found, hi_found, load, hs;
    logic                    r_hit, r_hs;

    assign load = !ar_valid_q | ar_ready_s;
    assign hs   = found & load & !rst;
    assign k    = r_id_s[TIDW+IW-1:TIDW];
    assign r_hs = r_valid_s & r_ready_s;

    // Eligibility: requesting and below the outstanding limit
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            elig[i] = ar_valid_m[i] & (cnt_q[i] < CW'(MAX_OUTST));
        end
    end

    // Round-robin pick: lowest eligible index >= rr, else lowest overall
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (elig[i]) begin
                lo_win = IW'(i);
                if (IW'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_win   = IW'(i);
                end
            end
        end
        found = |elig;
        win   = hi_found ? hi_win : lo_win;
    end

    // One-hot ARREADY toward the winning master
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            ar_ready_m[i] = hs & (win == IW'(i));
        end
    end

    // AR register, round-robin pointer and outstanding counters next state
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        rr_d       = rr_q;
        if (hs) begin
            ar_valid_d = 1'b1;
            rr_d = (win == IW'(NM - 1)) ? '0 : win + IW'(1);
            for (int i = 0; i < NM; i++) begin
                if (win == IW'(i)) begin
                    ar_id_d    = {IW'(i), ar_id_m[i]};
                    ar_addr_d  = ar_addr_m[i];
                    ar_len_d   = ar_len_m[i];
                    ar_size_d  = ar_size_m[i];
                    ar_burst_d = ar_burst_m[i];
                end
            end
        end else if (ar_ready_s) begin
            ar_valid_d = 1'b0;
        end
        for (int i = 0; i < NM; i++) begin
            logic inc, dec;
            inc = hs & (win == IW'(i));
            dec = r_hs & r_last_s & r_hit & (k == IW'(i))
                & (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc & !dec) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec & !inc) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ar_valid_s = ar_valid_q;
    assign ar_id_s    = ar_id_q;
    assign ar_addr_s  = ar_addr_q;
    assign ar_len_s   = ar_len_q;
    assign ar_size_s  = ar_size_q;
    assign ar_burst_s = ar_burst_q;

    // R routing by ID index; unknown indices are accepted and dropped
    always_comb begin
        r_valid_m = '0;
        r_ready_s = 1'b1;
        r_hit     = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (k == IW'(i)) begin
                r_hit        = 1'b1;
                r_valid_m[i] = r_valid_s;
                r_ready_s    = r_ready_m[i];
            end
        end
    end

    assign r_id_m   = r_id_s[TIDW-1:0];
    assign r_data_m = r_data_s;
    assign r_resp_m = r_resp_s;
    assign r_last_m = r_last_s;

`ifdef AXI_RD_ARB_ERR_EN
    logic err_q, err_d, k_zero;

    // Flag stray-index beats and last beats with nothing outstanding
    always_comb begin
        k_zero = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (k == IW'(i)) begin
                k_zero = (cnt_q[i] == '0);
            end
        end
        err_d = err_q | (r_hs & !r_hit)
              | (r_hs & r_last_s & r_hit & k_zero);
    end

    // Sticky error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (NM=3, MAX_OUTST=2).
// Directed steps followed by random traffic against a reference model.
module tb_axi_rd_arbiter;

    localparam int NM = 3;
    localparam int TIDW = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MAX_OUTST = 2;
    localparam int IW = 2;
`ifdef AXI_RD_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [NM-1:0][TIDW-1:0] ar_id_m;
    logic [NM-1:0][AW-1:0] ar_addr_m;
    logic [NM-1:0][7:0] ar_len_m;
    logic [NM-1:0][2:0] ar_size_m;
    logic [NM-1:0][1:0] ar_burst_m;
    logic [NM-1:0] ar_valid_m, ar_ready_m;
    logic [TIDW-1:0] r_id_m;
    logic [DW-1:0] r_data_m;
    logic [1:0] r_resp_m;
    logic r_last_m;
    logic [NM-1:0] r_valid_m, r_ready_m;
    logic [TIDW+IW-1:0] ar_id_s;
    logic [AW-1:0] ar_addr_s;
    logic [7:0] ar_len_s;
    logic [2:0] ar_size_s;
    logic [1:0] ar_burst_s;
    logic ar_valid_s, ar_ready_s;
    logic [TIDW+IW-1:0] r_id_s;
    logic [DW-1:0] r_data_s;
    logic [1:0] r_resp_s;
    logic r_last_s, r_valid_s, r_ready_s, err;

    axi_rd_arbiter #(
        .NM(NM), .TIDW(TIDW), .AW(AW), .DW(DW), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_id_m(ar_id_m), .ar_addr_m(ar_addr_m), .ar_len_m(ar_len_m),
        .ar_size_m(ar_size_m), .ar_burst_m(ar_burst_m),
        .ar_valid_m(ar_valid_m), .ar_ready_m(ar_ready_m),
        .r_id_m(r_id_m), .r_data_m(r_data_m), .r_resp_m(r_resp_m),
        .r_last_m(r_last_m), .r_valid_m(r_valid_m), .r_ready_m(r_ready_m),
        .ar_id_s(ar_id_s), .ar_addr_s(ar_addr_s), .ar_len_s(ar_len_s),
        .ar_size_s(ar_size_s), .ar_burst_s(ar_burst_s),
        .ar_valid_s(ar_valid_s), .ar_ready_s(ar_ready_s),
        .r_id_s(r_id_s), .r_data_s(r_data_s), .r_resp_s(r_resp_s),
        .r_last_s(r_last_s), .r_valid_s(r_valid_s), .r_ready_s(r_ready_s),
        .err(err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    // Reference model: registered AR, next-priority index, outstanding counts
    bit mvalid;
    logic [TIDW+IW-1:0] mid;
    logic [AW-1:0] maddr;
    logic [7:0] mlen;
    logic [2:0] msize;
    logic [1:0] mburst;
    int mrr;
    int mcnt[NM];
    bit merr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mvalid = 0; mid = '0; maddr = '0; mlen = '0;
        msize = '0; mburst = '0; mrr = 0; merr = 0;
        for (int i = 0; i < NM; i++) mcnt[i] = 0;
    endtask

    task automatic idle();
        ar_valid_m = '0; ar_ready_s = 1'b1; r_valid_s = 1'b0;
        r_last_s = 1'b0; r_ready_m = '0; r_id_s = '0;
        r_data_s = '0; r_resp_s = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model,
    // then check registered outputs just after the edge.
    task automatic step(output logic [NM-1:0] rdy, output logic [NM-1:0] rv,
                        output logic rrs);
        bit load, found, hs, rhs, exp_rrs;
        int w, c, k, inc_i, dec_i;
        logic [NM-1:0] exp_rdy, exp_rv;
        #4;
        rdy = ar_ready_m; rv = r_valid_m; rrs = r_ready_s;
        load = !mvalid || ar_ready_s;
        found = 0; w = 0;
        for (int j = 0; j < NM; j++) begin
            c = (mrr + j) % NM;
            if (!found && ar_valid_m[c] && mcnt[c] < MAX_OUTST) begin
                found = 1; w = c;
            end
        end
        hs = found && load && !rst;
        exp_rdy = '0;
        if (hs) exp_rdy[w] = 1'b1;
        chk("ar_ready_m", ar_ready_m, exp_rdy);
        k = int'(r_id_s[TIDW+IW-1:TIDW]);
        exp_rv = '0;
        if (k < NM) begin
            exp_rv[k] = r_valid_s;
            exp_rrs = r_ready_m[k];
        end else begin
            exp_rrs = 1'b1;
        end
        chk("r_valid_m", r_valid_m, exp_rv);
        chk("r_ready_s", r_ready_s, exp_rrs);
        chk("r_id_m", r_id_m, r_id_s[TIDW-1:0]);
        chk("r_data_m", r_data_m, r_data_s);
        chk("r_resp_m", r_resp_m, r_resp_s);
        chk("r_last_m", r_last_m, r_last_s);
        rhs = r_valid_s && exp_rrs;
        if (ERR_EN && rhs && (k >= NM || (r_last_s && mcnt[k] == 0)))
            merr = 1;
        inc_i = -1; dec_i = -1;
        if (hs) begin
            mvalid = 1;
            mid = {w[IW-1:0], ar_id_m[w]};
            maddr = ar_addr_m[w]; mlen = ar_len_m[w];
            msize = ar_size_m[w]; mburst = ar_burst_m[w];
            mrr = (w + 1) % NM;
            inc_i = w;
        end else if (ar_ready_s) begin
            mvalid = 0;
        end
        if (rhs && r_last_s && k < NM && mcnt[k] > 0) dec_i = k;
        if (inc_i != dec_i) begin
            if (inc_i >= 0) mcnt[inc_i]++;
            if (dec_i >= 0) mcnt[dec_i]--;
        end
        @(posedge clk);
        #1;
        chk("ar_valid_s", ar_valid_s, mvalid);
        chk("ar_id_s", ar_id_s, mid);
        chk("ar_addr_s", ar_addr_s, maddr);
        chk("ar_len_s", ar_len_s, mlen);
        chk("ar_size_s", ar_size_s, msize);
        chk("ar_burst_s", ar_burst_s, mburst);
        chk("err", err, merr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #4;
        chk("rst_ar_ready_m", ar_ready_m, 0);
        chk("rst_ar_valid_s", ar_valid_s, 0);
        chk("rst_ar_id_s", ar_id_s, 0);
        chk("rst_ar_addr_s", ar_addr_s, 0);
        chk("rst_err", err, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [NM-1:0] rdy, rv;
    logic rrs;
    logic [AW-1:0] saved_addr;
    logic [TIDW+IW-1:0] saved_id;
    int exp_idx[4] = '{0, 1, 0, 1};

    initial begin
        idle();
        for (int i = 0; i < NM; i++) begin
            ar_id_m[i] = TIDW'(i + 1);
            ar_addr_m[i] = AW'(16'h100 * (i + 1));
            ar_len_m[i] = 8'(i + 3);
            ar_size_m[i] = 3'(i + 1);
            ar_burst_m[i] = 2'b01;
        end
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ar_valid_s", ar_valid_s, 0);
        chk("reset_ar_ready_m", ar_ready_m, 0);
        chk("reset_ar_len_s", ar_len_s, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;

        // Two masters requesting: grants alternate 0,1,0,1
        ar_valid_m = 3'b011;
        for (int c = 0; c < 4; c++) begin
            step(rdy, rv, rrs);
            chk("alt_grant", rdy, 3'b001 << exp_idx[c]);
            chk("alt_idx", ar_id_s[TIDW+IW-1:TIDW], exp_idx[c]);
            chk("alt_valid", ar_valid_s, 1);
        end
        // Masters 0 and 1 full now
        step(rdy, rv, rrs);
        chk("full_block", rdy, 3'b000);
        ar_valid_m = 3'b111;
        step(rdy, rv, rrs);
        chk("full_other", rdy, 3'b100);
        // R last to master 0 frees a slot for the next cycle
        ar_valid_m = 3'b001;
        r_valid_s = 1'b1; r_last_s = 1'b1; r_ready_m = 3'b001;
        r_id_s = {2'd0, 2'd1}; r_data_s = 32'hCAFE0001;
        step(rdy, rv, rrs);
        chk("full_same", rdy, 3'b000);
        chk("full_rv", rv, 3'b001);
        idle();
        ar_valid_m = 3'b001;
        step(rdy, rv, rrs);
        chk("full_release", rdy, 3'b001);

        // Slave stall: payload stable, no grants
        ar_valid_m = 3'b110; ar_ready_s = 1'b0;
        saved_addr = ar_addr_s; saved_id = ar_id_s;
        for (int c = 0; c < 5; c++) begin
            step(rdy, rv, rrs);
            chk("stall_rdy", rdy, 3'b000);
            chk("stall_addr", ar_addr_s, saved_addr);
            chk("stall_id", ar_id_s, saved_id);
            chk("stall_valid", ar_valid_s, 1);
        end
        ar_ready_s = 1'b1;
        step(rdy, rv, rrs);
        chk("stall_release", rdy, 3'b100);

        // Four-beat burst to master 1 with one back-pressured cycle
        idle();
        r_valid_s = 1'b1; r_id_s = {2'd1, 2'd0};
        for (int c = 0; c < 5; c++) begin
            r_ready_m = (c == 1) ? 3'b000 : 3'b010;
            r_last_s = (c == 4);
            r_data_s = $urandom;
            step(rdy, rv, rrs);
            chk("burst_rv", rv, 3'b010);
            chk("burst_rrs", rrs, c != 1);
        end

        // Out-of-range index: accepted and dropped
        idle();
        r_valid_s = 1'b1; r_last_s = 1'b1; r_id_s = {2'd3, 2'd1};
        step(rdy, rv, rrs);
        chk("idx3_rv", rv, 3'b000);
        chk("idx3_rrs", rrs, 1);
        chk("idx3_err", err, ERR_EN);

        // Reset with a valid AR and master 0 at the limit
        idle();
        do_reset();
        ar_valid_m = 3'b001;
        step(rdy, rv, rrs);
        step(rdy, rv, rrs);
        chk("pre_rst_valid", ar_valid_s, 1);
        ar_ready_s = 1'b0;
        do_reset();
        chk("post_rst_valid", ar_valid_s, 0);
        chk("post_rst_err", err, 0);
        ar_ready_s = 1'b1; ar_valid_m = 3'b011;
        step(rdy, rv, rrs);
        chk("post_rst_rr", rdy, 3'b001);
        ar_valid_m = 3'b001;
        step(rdy, rv, rrs);
        chk("post_rst_cnt", rdy, 3'b001);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            ar_valid_m = NM'($urandom);
            for (int i = 0; i < NM; i++) begin
                ar_id_m[i] = TIDW'($urandom);
                ar_addr_m[i] = AW'($urandom);
                ar_len_m[i] = 8'($urandom);
                ar_size_m[i] = 3'($urandom);
                ar_burst_m[i] = 2'($urandom);
            end
            ar_ready_s = ($urandom_range(0, 3) != 0);
            r_valid_s = 1'($urandom);
            r_id_s = (TIDW + IW)'($urandom);
            r_last_s = 1'($urandom);
            r_ready_m = NM'($urandom);
            r_data_s = $urandom;
            r_resp_s = 2'($urandom);
            step(rdy, rv, rrs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
